// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan chain driver:
//   - scan_drv_state_e : driver FSM states
//   - scan_ctrl_t      : scan control bundle (sclkp, sclkn, senable, supdate, sreset)
//   - default values for the ChainLen / PhaseCyc parameters
//   - ctrl_for_state() : scan control levels held while in a given state
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int unsigned CHAIN_LEN_DEFAULT = 64;
    localparam int unsigned PHASE_CYC_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_P,
        GAP_P,
        SHIFT_N,
        GAP_N,
        UPDATE,
        RESET_PULSE
    } scan_drv_state_e;

    typedef struct packed {
        logic sclkp;
        logic sclkn;
        logic senable;
        logic supdate;
        logic sreset;
    } scan_ctrl_t;

    function automatic scan_ctrl_t ctrl_for_state(input scan_drv_state_e s);
        scan_ctrl_t c;
        c         = '0;
        c.sclkp   = (s == SHIFT_P);
        c.sclkn   = (s == SHIFT_N);
        c.senable = (s == SHIFT_P) || (s == GAP_P) || (s == SHIFT_N) || (s == GAP_N);
        c.supdate = (s == UPDATE);
        c.sreset  = (s == RESET_PULSE);
        return c;
    endfunction

endpackage

// File: rtl/scan_if.sv
// -----------------------------------------------------------------------------
// scan_if
// Scan chain bus between the driver and the chain.
//   sdata : serial data, MSB of the word first
//   sctrl : scan control bundle (see scan_pkg::scan_ctrl_t)
// Modports: send (driver side), recv (chain side).
// -----------------------------------------------------------------------------
interface scan_if;
    import scan_pkg::*;

    logic       sdata;
    scan_ctrl_t sctrl;

    modport send (output sdata, output sctrl);
    modport recv (input  sdata, input  sctrl);
endinterface

// File: rtl/scan_phase_timer.sv
// -----------------------------------------------------------------------------
// scan_phase_timer
// Down-counter timing how long the driver stays in one scan phase.
// Ports:
//   i_clk      : clock (rising edge)
//   i_rst      : synchronous active-high reset
//   i_load     : load i_load_val (asserted on every state change)
//   i_load_val : cycles remaining minus one (PhaseCyc-1 for pulses, 0 for gaps)
//   o_expired  : current cycle is the last one of the phase
// The counter saturates at zero, so it never wraps.
// -----------------------------------------------------------------------------
module scan_phase_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    output logic             o_expired
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - Width'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/scan_driver.sv
// -----------------------------------------------------------------------------
// scan_driver
// Serialises a ChainLen-bit word into a scan chain with two non-overlapping
// scan clocks, followed by an update pulse, or issues a chain reset pulse.
// Ports:
//   clk       : clock (rising edge)
//   rst       : synchronous active-high reset; aborts any operation
//   req_valid : request present
//   req_ready : driver idle, request is accepted on this edge if req_valid
//   req_reset : 1 = chain reset, 0 = shift-and-update
//   req_data  : word to shift, bit ChainLen-1 first
//   busy      : operation in progress
//   done      : one-cycle pulse in the first idle cycle after an operation
//   scan      : scan bus (sdata + sctrl), all driven from registers
// -----------------------------------------------------------------------------
module scan_driver
    import scan_pkg::*;
#(
    parameter int unsigned ChainLen = CHAIN_LEN_DEFAULT,
    parameter int unsigned PhaseCyc = PHASE_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_reset,
    input  logic [ChainLen-1:0] req_data,
    output logic                busy,
    output logic                done,
    scan_if.send                scan
);

    localparam int unsigned BIT_W = $clog2(ChainLen + 1);
    localparam int unsigned PH_W  = $clog2(PhaseCyc + 1);
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(PhaseCyc - 1);

    scan_drv_state_e r_state;
    scan_drv_state_e w_state_nxt;

    logic [ChainLen-1:0] r_shreg;
    logic [BIT_W-1:0]    r_bits_left;
    logic                r_sdata;
    scan_ctrl_t          r_sctrl;
    logic                r_done;

    logic                w_accept;
    logic                w_ph_load;
    logic [PH_W-1:0]     w_ph_val;
    logic                w_ph_expired;
    logic                w_next_bit;

    scan_phase_timer #(
        .Width (PH_W)
    ) u_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_val),
        .o_expired  (w_ph_expired)
    );

    // Next-state logic; the phase timer is reloaded on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_next_bit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = req_reset ? RESET_PULSE : SHIFT_P;
                end
            end
            SHIFT_P:     if (w_ph_expired) w_state_nxt = GAP_P;
            GAP_P:       if (w_ph_expired) w_state_nxt = SHIFT_N;
            SHIFT_N:     if (w_ph_expired) w_state_nxt = GAP_N;
            GAP_N: begin
                if (w_ph_expired) begin
                    if (r_bits_left > BIT_W'(1)) begin
                        w_next_bit  = 1'b1;
                        w_state_nxt = SHIFT_P;
                    end else begin
                        w_state_nxt = UPDATE;
                    end
                end
            end
            UPDATE:      if (w_ph_expired) w_state_nxt = IDLE;
            RESET_PULSE: if (w_ph_expired) w_state_nxt = IDLE;
            default:     w_state_nxt = IDLE;
        endcase

        w_ph_load = (w_state_nxt != r_state);
        w_ph_val  = ((w_state_nxt == GAP_P) || (w_state_nxt == GAP_N) || (w_state_nxt == IDLE))
                    ? '0 : PH_LOAD;
    end

    // Scan outputs are decoded from the next state and registered together
    // with it, so they line up with the state without a combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_sdata     <= 1'b0;
            r_sctrl     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sctrl <= ctrl_for_state(w_state_nxt);
            r_done  <= ((r_state == UPDATE) || (r_state == RESET_PULSE)) && (w_state_nxt == IDLE);

            if (w_accept && !req_reset) begin
                r_sdata     <= req_data[ChainLen-1];
                r_shreg     <= req_data << 1;
                r_bits_left <= BIT_W'(ChainLen);
            end else if (w_next_bit) begin
                r_sdata     <= r_shreg[ChainLen-1];
                r_shreg     <= r_shreg << 1;
                r_bits_left <= r_bits_left - BIT_W'(1);
            end else if (!ctrl_for_state(w_state_nxt).senable) begin
                r_sdata <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = ~req_ready;
    assign done       = r_done;
    assign scan.sdata = r_sdata;
    assign scan.sctrl = r_sctrl;

endmodule

// File: tb/tb_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_scan_driver
// Five scan_driver instances with different ChainLen/PhaseCyc share one set of
// request inputs; tb_sel routes req_valid to one instance and selects which
// instance's outputs the directed checks observe.
//   0: ChainLen=8 PhaseCyc=2   1: ChainLen=8 PhaseCyc=1   2: ChainLen=8 PhaseCyc=16
//   3: ChainLen=8 PhaseCyc=3   4: ChainLen=1 PhaseCyc=2
// -----------------------------------------------------------------------------
module tb_scan_driver;
    import scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_valid = 1'b0;
    logic       tb_rreq = 1'b0;
    logic [7:0] tb_data = '0;
    logic [2:0] tb_sel = '0;

    logic [4:0] o_busy, o_done, o_ready, o_sdata;
    scan_ctrl_t o_ctl [5];

    logic       m_busy, m_done, m_ready, m_sdata;
    scan_ctrl_t m_ctl;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int unsigned CL = (g == 4) ? 1 : 8;
        localparam int unsigned PC = (g == 1) ? 1 : (g == 2) ? 16 : (g == 3) ? 3 : 2;
        scan_if u_if ();
        logic w_valid;
        assign w_valid = tb_valid && (tb_sel == 3'(g));
        scan_driver #(.ChainLen(CL), .PhaseCyc(PC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (w_valid),
            .req_ready (o_ready[g]),
            .req_reset (tb_rreq),
            .req_data  (tb_data[CL-1:0]),
            .busy      (o_busy[g]),
            .done      (o_done[g]),
            .scan      (u_if.send)
        );
        assign o_sdata[g] = u_if.sdata;
        assign o_ctl[g]   = u_if.sctrl;
    end

    assign m_busy  = o_busy[tb_sel];
    assign m_done  = o_done[tb_sel];
    assign m_ready = o_ready[tb_sel];
    assign m_sdata = o_sdata[tb_sel];
    assign m_ctl   = o_ctl[tb_sel];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Protocol checks on every instance, every cycle.
    logic [4:0] prev_p = '0;
    logic [4:0] prev_n = '0;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                assert (!(o_ctl[i].sclkp && o_ctl[i].sclkn) &&
                        !(prev_p[i] && o_ctl[i].sclkn) &&
                        !(prev_n[i] && o_ctl[i].sclkp) &&
                        !(o_ctl[i].senable && (o_ctl[i].supdate || o_ctl[i].sreset)))
                else begin
                    n_bad++;
                    $display("FAIL nonoverlap[%0d]: sctrl=%b prev_p=%b prev_n=%b", i, o_ctl[i], prev_p[i], prev_n[i]);
                end
                n_cmp++;
                assert (!o_ready[i] || (o_ctl[i] == '0 && o_sdata[i] == 1'b0 && o_busy[i] == 1'b0))
                else begin
                    n_bad++;
                    $display("FAIL idle_quiet[%0d]: sctrl=%b sdata=%b busy=%b, expected all 0", i, o_ctl[i], o_sdata[i], o_busy[i]);
                end
                prev_p[i] = o_ctl[i].sclkp;
                prev_n[i] = o_ctl[i].sclkn;
            end
        end
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        bit         is_rst;
        int         exp_done;
        int         exp_p_pulses;
        int         exp_p_cycles;
        int         exp_n_cycles;
        int         exp_upd_first;
        int         exp_upd_cycles;
        int         exp_rst_cycles;
        logic [7:0] exp_bits;
    } vec_t;

    function automatic vec_t mk(input int sel, input logic [7:0] data, input bit is_rst,
                                input int dn, input int pp, input int pc, input int nc,
                                input int uf, input int uc, input int rc, input logic [7:0] bits);
        vec_t v;
        v.sel = sel; v.data = data; v.is_rst = is_rst; v.exp_done = dn;
        v.exp_p_pulses = pp; v.exp_p_cycles = pc; v.exp_n_cycles = nc;
        v.exp_upd_first = uf; v.exp_upd_cycles = uc; v.exp_rst_cycles = rc; v.exp_bits = bits;
        return v;
    endfunction

    // Cycle numbers are relative to the accepting edge k (cycle 1 = k+1).
    task automatic run_vec(input vec_t v, input int idx);
        int         cyc, done_cyc, p_pul, p_cyc, n_cyc, upd_first, upd_cyc, rst_cyc, unstable;
        logic [7:0] bits;
        logic       prev_pl, cur_bit;
        string      t;
        t = $sformatf("vec%0d", idx);
        cyc = 0; done_cyc = 0; p_pul = 0; p_cyc = 0; n_cyc = 0;
        upd_first = 0; upd_cyc = 0; rst_cyc = 0; unstable = 0;
        bits = '0; prev_pl = 1'b0; cur_bit = 1'b0;

        @(negedge clk);
        tb_sel = v.sel[2:0]; tb_data = v.data; tb_rreq = v.is_rst; tb_valid = 1'b1;
        #1;
        chk({t, "_ready_before"}, int'(m_ready), 1);
        @(posedge clk);
        #1 tb_valid = 1'b0;

        while (done_cyc == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (m_ctl.sclkp && !prev_pl) begin
                p_pul++;
                bits    = {bits[6:0], m_sdata};
                cur_bit = m_sdata;
            end
            if (m_ctl.senable && (m_sdata !== cur_bit)) unstable++;
            p_cyc += int'(m_ctl.sclkp);
            n_cyc += int'(m_ctl.sclkn);
            if (m_ctl.supdate) begin
                if (upd_first == 0) upd_first = cyc;
                upd_cyc++;
            end
            rst_cyc += int'(m_ctl.sreset);
            prev_pl = m_ctl.sclkp;
            if (m_done) begin
                done_cyc = cyc;
                chk({t, "_ready_at_done"}, int'(m_ready), 1);
            end
        end

        chk({t, "_done_cycle"}, done_cyc, v.exp_done);
        chk({t, "_sclkp_pulses"}, p_pul, v.exp_p_pulses);
        chk({t, "_sclkp_cycles"}, p_cyc, v.exp_p_cycles);
        chk({t, "_sclkn_cycles"}, n_cyc, v.exp_n_cycles);
        chk({t, "_supdate_first"}, upd_first, v.exp_upd_first);
        chk({t, "_supdate_cycles"}, upd_cyc, v.exp_upd_cycles);
        chk({t, "_sreset_cycles"}, rst_cyc, v.exp_rst_cycles);
        chk({t, "_sdata_bits"}, int'(bits), int'(v.exp_bits));
        chk({t, "_sdata_unstable"}, unstable, 0);
        @(negedge clk);
        chk({t, "_done_width"}, int'(m_done), 0);
    endtask

    vec_t tbl [11];

    initial begin
        logic [7:0] r1, r2, r3;
        int         cyc, done_cyc, rises, upd_seen, done_seen;
        logic       prev_pl;

        r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
        //           sel data   rst done pp  pc   nc   uf   uc  rc bits
        tbl[0]  = mk(0, 8'hA5, 0,  51, 8,  16,  16,  49,  2, 0, 8'hA5);
        tbl[1]  = mk(0, 8'h3C, 0,  51, 8,  16,  16,  49,  2, 0, 8'h3C);
        tbl[2]  = mk(0, 8'h00, 0,  51, 8,  16,  16,  49,  2, 0, 8'h00);
        tbl[3]  = mk(0, 8'hFF, 0,  51, 8,  16,  16,  49,  2, 0, 8'hFF);
        tbl[4]  = mk(0, 8'h5A, 1,   3, 0,   0,   0,   0,  0, 2, 8'h00);
        tbl[5]  = mk(1, r1,    0,  34, 8,   8,   8,  33,  1, 0, r1);
        tbl[6]  = mk(1, r2,    0,  34, 8,   8,   8,  33,  1, 0, r2);
        tbl[7]  = mk(2, r3,    0, 289, 8, 128, 128, 273, 16, 0, r3);
        tbl[8]  = mk(3, 8'hC3, 1,   4, 0,   0,   0,   0,  0, 3, 8'h00);
        tbl[9]  = mk(4, 8'h01, 0,   9, 1,   2,   2,   7,  2, 0, 8'h01);
        tbl[10] = mk(3, 8'h5A, 0,  68, 8,  24,  24,  65,  3, 0, 8'h5A);

        // Reset state, checked while rst is still held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            tb_sel = 3'(s);
            #1;
            chk($sformatf("rst%0d_sdata", s), int'(m_sdata), 0);
            chk($sformatf("rst%0d_sctrl", s), int'(m_ctl), 0);
            chk($sformatf("rst%0d_busy", s), int'(m_busy), 0);
            chk($sformatf("rst%0d_done", s), int'(m_done), 0);
            chk($sformatf("rst%0d_ready", s), int'(m_ready), 1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // Back-to-back: req_valid held across done on instance 0.
        @(negedge clk);
        tb_sel = 3'd0; tb_data = 8'h81; tb_rreq = 1'b0; tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_data = 8'h7E;
        cyc = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("b2b_first_sdata", int'(m_sdata), 1);
            if (m_done) done_cyc = cyc;
        end
        chk("b2b_done1_cycle", done_cyc, 51);
        chk("b2b_ready_at_done", int'(m_ready), 1);
        @(posedge clk);
        #1 tb_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_sclkp", int'(m_ctl.sclkp), 1);
        chk("b2b_second_sdata", int'(m_sdata), 0);
        chk("b2b_second_busy", int'(m_busy), 1);
        cyc = 1; done_cyc = 0;
        while (done_cyc == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m_done) done_cyc = cyc;
        end
        chk("b2b_done2_cycle", done_cyc, 51);

        // Mid-operation reset during bit 3, with a request presented under rst.
        @(negedge clk);
        tb_sel = 3'd0; tb_data = 8'hA5; tb_rreq = 1'b0; tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        rises = 0; prev_pl = 1'b0; cyc = 0;
        while (rises < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (m_ctl.sclkp && !prev_pl) rises++;
            prev_pl = m_ctl.sclkp;
        end
        chk("midrst_reached_bit3", rises, 3);
        rst = 1'b1; tb_valid = 1'b1; tb_data = 8'hFF;
        @(posedge clk);
        #1 rst = 1'b0; tb_valid = 1'b0;
        @(negedge clk);
        chk("midrst_sdata", int'(m_sdata), 0);
        chk("midrst_sctrl", int'(m_ctl), 0);
        chk("midrst_busy", int'(m_busy), 0);
        chk("midrst_done", int'(m_done), 0);
        upd_seen = 0; done_seen = 0;
        repeat (60) begin
            @(negedge clk);
            upd_seen  += int'(m_ctl.supdate);
            done_seen += int'(m_done);
        end
        chk("midrst_no_supdate", upd_seen, 0);
        chk("midrst_no_done", done_seen, 0);
        run_vec(tbl[0], 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
